// File: rtl/core_slot_tracker_pkg.sv
// Shared scheduler/core message definitions.
// Holds the message type codes carried in tdata[63:56], the scheduler's
// reset command word and the tracker FSM state type.
package core_slot_tracker_pkg;

   localparam logic [7:0]  MsgTypeDesc      = 8'd0;
   localparam logic [7:0]  MsgTypeLoopback  = 8'd1;
   localparam logic [7:0]  MsgTypeSlotCount = 8'd4;
   localparam logic [63:0] ResetCmd         = 64'hFFFF_FFFF_FFFF_FFFE;

   typedef enum logic [1:0] {
      StIdle,
      StInit,
      StRun
   } state_e;

endpackage

// File: rtl/simple_fifo.sv
// Synchronous FIFO with arbitrary depth.
// Ports: clk_i/rst_i (sync active-high), clr_i flushes contents,
//        wr_en_i/wr_data_i push (ignored when full),
//        rd_en_i pop (ignored when empty), rd_data_o shows the head,
//        empty_o/full_o occupancy flags.
module simple_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_wr, do_rd;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CntW'(Depth));
   assign do_wr     = wr_en_i && !full_o;
   assign do_rd     = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (do_wr && !do_rd) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (do_rd && !do_wr) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/core_slot_tracker.sv
// Tracks packet-slot occupancy for one core and relays messages between the
// scheduler and the core.
// Ports: clk/rst (sync active-high);
//        ctrl_s_axis_*  scheduler commands (reset command, type-0 descriptors);
//        ctrl_m_axis_*  messages to scheduler (type 4 slot count, type 0 release);
//        rx_done_*      packet landed in a slot; rel_*  core releases a slot;
//        desc_*         descriptor forwarded to the core; core_reset pulse;
//        slot_busy      occupancy bitmap; err sticky protocol error.
module core_slot_tracker
   import core_slot_tracker_pkg::*;
#(
   parameter int unsigned SLOT_COUNT = 8,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned SLOT_WIDTH = $clog2(SLOT_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ctrl_s_axis_tdata,
   input  logic                  ctrl_s_axis_tvalid,
   output logic                  ctrl_s_axis_tready,
   input  logic                  ctrl_s_axis_tlast,
   output logic [DATA_WIDTH-1:0] ctrl_m_axis_tdata,
   output logic                  ctrl_m_axis_tvalid,
   input  logic                  ctrl_m_axis_tready,
   output logic                  ctrl_m_axis_tlast,
   input  logic                  rx_done_valid,
   input  logic [SLOT_WIDTH-1:0] rx_done_slot,
   input  logic                  rel_valid,
   output logic                  rel_ready,
   input  logic [SLOT_WIDTH-1:0] rel_slot,
   input  logic [LEN_WIDTH-1:0]  rel_len,
   output logic                  desc_valid,
   input  logic                  desc_ready,
   output logic [DATA_WIDTH-1:0] desc_data,
   output logic                  core_reset,
   output logic [SLOT_COUNT-1:0] slot_busy,
   output logic                  err
);

   localparam int unsigned EntryW = SLOT_WIDTH + LEN_WIDTH;

   state_e                state_q, state_d;
   logic [SLOT_COUNT-1:0] busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  core_reset_q;
   logic                  out_valid_q, out_valid_d;
   logic [EntryW-1:0]     out_entry_q, out_entry_d;
   logic                  desc_valid_q, desc_valid_d;
   logic [DATA_WIDTH-1:0] desc_data_q, desc_data_d;

   logic [SLOT_COUNT-1:0] rel_hot, rx_hot;
   logic                  rst_cmd, is_desc, s_acc, desc_ld, drop_err;
   logic                  rel_acc, rel_ok, rel_push, rx_ok;
   logic                  out_pop, fifo_rd, fifo_empty, fifo_full;
   logic [EntryW-1:0]     fifo_rd_data;
   logic                  unused_tlast;

   assign unused_tlast = ctrl_s_axis_tlast;

   // Slot numbers are 1-based; 0 and out-of-range numbers decode to no bit.
   always_comb begin
      rel_hot = '0;
      rx_hot  = '0;
      for (int unsigned k = 0; k < SLOT_COUNT; k++) begin
         rel_hot[k] = (rel_slot == SLOT_WIDTH'(k + 1));
         rx_hot[k]  = (rx_done_slot == SLOT_WIDTH'(k + 1));
      end
   end

   // Reset command is always accepted; type-0 words in RUN backpressure on the
   // descriptor register, anything else is swallowed.
   assign rst_cmd  = ctrl_s_axis_tvalid && (ctrl_s_axis_tdata == DATA_WIDTH'(ResetCmd));
   assign is_desc  = !rst_cmd && (state_q == StRun) &&
                     (ctrl_s_axis_tdata[DATA_WIDTH-1 -: 8] == MsgTypeDesc);
   assign ctrl_s_axis_tready = is_desc ? (!desc_valid_q || desc_ready) : 1'b1;
   assign s_acc    = ctrl_s_axis_tvalid && ctrl_s_axis_tready;
   assign desc_ld  = s_acc && is_desc;
   assign drop_err = s_acc && !rst_cmd && !is_desc;

   assign rel_ready = (state_q == StRun) && !fifo_full;
   assign rel_acc   = rel_valid && rel_ready;
   assign rel_ok    = |(rel_hot & busy_q);
   assign rel_push  = rel_acc && rel_ok;
   assign rx_ok     = (state_q == StRun) && (|rx_hot) && !(|(rx_hot & busy_q));

   assign out_pop = out_valid_q && ctrl_m_axis_tready;
   assign fifo_rd = !fifo_empty && (!out_valid_q || out_pop) && !rst_cmd;

   simple_fifo #(
      .Depth (SLOT_COUNT),
      .Width (EntryW)
   ) u_rel_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (rst_cmd),
      .wr_en_i   (rel_push),
      .wr_data_i ({rel_slot, rel_len}),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      err_d        = err_q;
      out_valid_d  = out_valid_q;
      out_entry_d  = out_entry_q;
      desc_valid_d = desc_valid_q;
      desc_data_d  = desc_data_q;

      unique case (state_q)
         StInit:  if (ctrl_m_axis_tready) state_d = StRun;
         default: ;
      endcase

      // Release clears and rx_done sets, both judged on the pre-cycle bitmap.
      busy_d = (busy_q & ~(rel_push ? rel_hot : '0)) |
               ((rx_done_valid && rx_ok) ? rx_hot : '0);

      if ((rel_acc && !rel_ok) || (rx_done_valid && !rx_ok) || drop_err) begin
         err_d = 1'b1;
      end

      if (out_pop) out_valid_d = 1'b0;
      if (fifo_rd) begin
         out_valid_d = 1'b1;
         out_entry_d = fifo_rd_data;
      end

      if (desc_valid_q && desc_ready) desc_valid_d = 1'b0;
      if (desc_ld) begin
         desc_valid_d = 1'b1;
         desc_data_d  = ctrl_s_axis_tdata;
      end

      if (rst_cmd) begin
         state_d     = StInit;
         busy_d      = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         busy_q       <= '0;
         err_q        <= 1'b0;
         core_reset_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_entry_q  <= '0;
         desc_valid_q <= 1'b0;
         desc_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         core_reset_q <= rst_cmd;
         out_valid_q  <= out_valid_d;
         out_entry_q  <= out_entry_d;
         desc_valid_q <= desc_valid_d;
         desc_data_q  <= desc_data_d;
      end
   end

   // INIT owns ctrl_m exclusively; the output register is empty there.
   always_comb begin
      ctrl_m_axis_tdata = '0;
      if (state_q == StInit) begin
         ctrl_m_axis_tdata[DATA_WIDTH-1 -: 8] = MsgTypeSlotCount;
         ctrl_m_axis_tdata[SLOT_WIDTH-1:0]    = SLOT_WIDTH'(SLOT_COUNT);
      end else begin
         ctrl_m_axis_tdata[DATA_WIDTH-1 -: 8] = MsgTypeDesc;
         ctrl_m_axis_tdata[EntryW-1:0]        = out_entry_q;
      end
   end

   assign ctrl_m_axis_tvalid = (state_q == StInit) || out_valid_q;
   assign ctrl_m_axis_tlast  = 1'b1;
   assign desc_valid         = desc_valid_q;
   assign desc_data          = desc_data_q;
   assign core_reset         = core_reset_q;
   assign slot_busy          = busy_q;
   assign err                = err_q;

endmodule

// File: tb/tb_core_slot_tracker.sv
module tb_core_slot_tracker;

   localparam int unsigned SlotCount = 8;
   localparam int unsigned DataW     = 64;
   localparam int unsigned LenW      = 16;
   localparam int unsigned SlotW     = 4;
   localparam logic [63:0] RstCmdWord = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [63:0] InitWord   = 64'h0400_0000_0000_0008;

   logic             clk = 1'b0;
   logic             rst;
   logic [DataW-1:0] ctrl_s_axis_tdata;
   logic             ctrl_s_axis_tvalid, ctrl_s_axis_tready, ctrl_s_axis_tlast;
   logic [DataW-1:0] ctrl_m_axis_tdata;
   logic             ctrl_m_axis_tvalid, ctrl_m_axis_tready, ctrl_m_axis_tlast;
   logic             rx_done_valid;
   logic [SlotW-1:0] rx_done_slot;
   logic             rel_valid, rel_ready;
   logic [SlotW-1:0] rel_slot;
   logic [LenW-1:0]  rel_len;
   logic             desc_valid, desc_ready;
   logic [DataW-1:0] desc_data;
   logic             core_reset;
   logic [SlotCount-1:0] slot_busy;
   logic             err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   core_slot_tracker dut (
      .clk                (clk),
      .rst                (rst),
      .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
      .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
      .ctrl_s_axis_tready (ctrl_s_axis_tready),
      .ctrl_s_axis_tlast  (ctrl_s_axis_tlast),
      .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
      .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
      .ctrl_m_axis_tready (ctrl_m_axis_tready),
      .ctrl_m_axis_tlast  (ctrl_m_axis_tlast),
      .rx_done_valid      (rx_done_valid),
      .rx_done_slot       (rx_done_slot),
      .rel_valid          (rel_valid),
      .rel_ready          (rel_ready),
      .rel_slot           (rel_slot),
      .rel_len            (rel_len),
      .desc_valid         (desc_valid),
      .desc_ready         (desc_ready),
      .desc_data          (desc_data),
      .core_reset         (core_reset),
      .slot_busy          (slot_busy),
      .err                (err)
   );

   function automatic logic [63:0] rel_word(input int slot, input int len);
      return (64'(slot) << 16) | 64'(len);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ctrl_s_axis_tdata  = '0;
      ctrl_s_axis_tvalid = 1'b0;
      ctrl_s_axis_tlast  = 1'b1;
      ctrl_m_axis_tready = 1'b0;
      rx_done_valid      = 1'b0;
      rx_done_slot       = '0;
      rel_valid          = 1'b0;
      rel_slot           = '0;
      rel_len            = '0;
      desc_ready         = 1'b0;
   endtask

   task automatic apply_rst();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reset command, then accept the slot-count announcement.
   task automatic enter_run();
      ctrl_s_axis_tdata  = RstCmdWord;
      ctrl_s_axis_tvalid = 1'b1;
      tick();
      ctrl_s_axis_tvalid = 1'b0;
      ctrl_m_axis_tready = 1'b1;
      tick();
      ctrl_m_axis_tready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      // A reset command during rst must be ignored.
      ctrl_s_axis_tdata  = RstCmdWord;
      ctrl_s_axis_tvalid = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      ctrl_s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got %b exp 0", ctrl_m_axis_tvalid); end
      n_tests++;
      if (desc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_desc_valid got %b exp 0", desc_valid); end
      n_tests++;
      if (core_reset !== 1'b0) begin n_fail++; $display("FAIL rst_core_reset got %b exp 0", core_reset); end
      n_tests++;
      if (rel_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rel_ready got %b exp 0", rel_ready); end
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
      n_tests++;
      if (slot_busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy got %h exp 00", slot_busy); end
      tick();
      @(negedge clk);
      n_tests++;
      if (core_reset !== 1'b0 || ctrl_m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL rst_override got core_reset=%b mvalid=%b exp 0 0", core_reset, ctrl_m_axis_tvalid);
      end
   endtask

   task automatic test_init();
      tick();
      ctrl_s_axis_tdata  = RstCmdWord;
      ctrl_s_axis_tvalid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctrl_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL init_cmd_ready got %b exp 1", ctrl_s_axis_tready); end
      tick();
      ctrl_s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (core_reset !== 1'b1) begin n_fail++; $display("FAIL init_core_reset got %b exp 1", core_reset); end
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== InitWord) begin
         n_fail++; $display("FAIL init_word got v=%b %h exp v=1 %h", ctrl_m_axis_tvalid, ctrl_m_axis_tdata, InitWord);
      end
      n_tests++;
      if (rel_ready !== 1'b0) begin n_fail++; $display("FAIL init_rel_ready got %b exp 0", rel_ready); end
      tick();
      @(negedge clk);
      n_tests++;
      if (core_reset !== 1'b0) begin n_fail++; $display("FAIL init_pulse_len got %b exp 0", core_reset); end
      n_tests++;
      if (ctrl_m_axis_tdata !== InitWord) begin n_fail++; $display("FAIL init_hold got %h exp %h", ctrl_m_axis_tdata, InitWord); end
      tick();
      ctrl_m_axis_tready = 1'b1;
      tick();
      ctrl_m_axis_tready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b0 || rel_ready !== 1'b1) begin
         n_fail++; $display("FAIL init_to_run got mvalid=%b rel_ready=%b exp 0 1", ctrl_m_axis_tvalid, rel_ready);
      end
   endtask

   task automatic test_release();
      tick();
      rx_done_valid = 1'b1;
      rx_done_slot  = 4'd3;
      tick();
      rx_done_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (slot_busy !== 8'h04) begin n_fail++; $display("FAIL rel_busy_set got %h exp 04", slot_busy); end
      tick();
      rel_valid = 1'b1; rel_slot = 4'd3; rel_len = 16'd64;
      @(negedge clk);
      n_tests++;
      if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b exp 1", rel_ready); end
      tick();
      rel_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (slot_busy !== 8'h00 || ctrl_m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL rel_n1 got busy=%h mvalid=%b exp 00 0", slot_busy, ctrl_m_axis_tvalid);
      end
      tick();
      ctrl_m_axis_tready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== 64'h0000_0000_0003_0040) begin
         n_fail++; $display("FAIL rel_word got v=%b %h exp v=1 0000000000030040", ctrl_m_axis_tvalid, ctrl_m_axis_tdata);
      end
      tick();
      ctrl_m_axis_tready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rel_drained got %b exp 0", ctrl_m_axis_tvalid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_words [9];
      for (int s = 1; s <= 8; s++) begin
         tick();
         rx_done_valid = 1'b1;
         rx_done_slot  = SlotW'(s);
      end
      tick();
      rx_done_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (slot_busy !== 8'hFF) begin n_fail++; $display("FAIL b2b_all_busy got %h exp ff", slot_busy); end
      for (int i = 0; i < 8; i++) begin
         tick();
         rel_valid = 1'b1; rel_slot = SlotW'(i + 1); rel_len = LenW'(16'h100 + i);
         exp_words[i] = rel_word(i + 1, 16'h100 + i);
         @(negedge clk);
         n_tests++;
         if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b exp 1", i, rel_ready); end
      end
      tick();
      rel_valid = 1'b0;
      rx_done_valid = 1'b1; rx_done_slot = 4'd1;
      tick();
      rx_done_valid = 1'b0;
      rel_valid = 1'b1; rel_slot = 4'd1; rel_len = 16'h2AA;
      exp_words[8] = rel_word(1, 16'h2AA);
      @(negedge clk);
      n_tests++;
      if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_9 got %b exp 1", rel_ready); end
      tick();
      rel_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rel_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b exp 0", rel_ready); end
      for (int i = 0; i < 9; i++) begin
         tick();
         @(negedge clk);
         n_tests++;
         if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== exp_words[0]) begin
            n_fail++; $display("FAIL b2b_stall_%0d got v=%b %h exp v=1 %h", i, ctrl_m_axis_tvalid, ctrl_m_axis_tdata, exp_words[0]);
         end
      end
      tick();
      ctrl_m_axis_tready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         n_tests++;
         if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== exp_words[i]) begin
            n_fail++; $display("FAIL b2b_drain_%0d got v=%b %h exp v=1 %h", i, ctrl_m_axis_tvalid, ctrl_m_axis_tdata, exp_words[i]);
         end
         tick();
      end
      ctrl_m_axis_tready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b0 || slot_busy !== 8'h00 || rel_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_end got v=%b busy=%h rel_ready=%b exp 0 00 1", ctrl_m_axis_tvalid, slot_busy, rel_ready);
      end
   endtask

   task automatic test_reset_flush();
      for (int s = 1; s <= 4; s++) begin
         tick();
         rx_done_valid = 1'b1; rx_done_slot = SlotW'(s);
      end
      tick();
      rx_done_valid = 1'b0;
      for (int s = 1; s <= 4; s++) begin
         rel_valid = 1'b1; rel_slot = SlotW'(s); rel_len = LenW'(16'h10 + s);
         tick();
      end
      rel_valid = 1'b0;
      ctrl_s_axis_tdata  = RstCmdWord;
      ctrl_s_axis_tvalid = 1'b1;
      tick();
      ctrl_s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (core_reset !== 1'b1 || slot_busy !== 8'h00) begin
         n_fail++; $display("FAIL flush_pulse got core_reset=%b busy=%h exp 1 00", core_reset, slot_busy);
      end
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== InitWord) begin
         n_fail++; $display("FAIL flush_init got v=%b %h exp v=1 %h", ctrl_m_axis_tvalid, ctrl_m_axis_tdata, InitWord);
      end
      tick();
      ctrl_m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         n_tests++;
         if (ctrl_m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_%0d got %b exp 0", i, ctrl_m_axis_tvalid); end
      end
      tick();
      ctrl_m_axis_tready = 1'b0;
   endtask

   task automatic test_desc();
      logic [63:0] w1, w2;
      w1 = 64'h00AB_CDEF_0123_4567;
      w2 = 64'h0012_3456_789A_BCDE;
      tick();
      ctrl_s_axis_tdata = w1; ctrl_s_axis_tvalid = 1'b1; desc_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL desc_first_ready got %b exp 1", ctrl_s_axis_tready); end
      tick();
      ctrl_s_axis_tdata = w2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (desc_valid !== 1'b1 || desc_data !== w1 || ctrl_s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL desc_hold_%0d got v=%b %h sready=%b exp v=1 %h sready=0", i, desc_valid, desc_data, ctrl_s_axis_tready, w1);
         end
         tick();
      end
      desc_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctrl_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL desc_release_ready got %b exp 1", ctrl_s_axis_tready); end
      tick();
      ctrl_s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (desc_valid !== 1'b1 || desc_data !== w2) begin
         n_fail++; $display("FAIL desc_second got v=%b %h exp v=1 %h", desc_valid, desc_data, w2);
      end
      tick();
      desc_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (desc_valid !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL desc_empty got v=%b err=%b exp 0 0", desc_valid, err);
      end
      tick();
      ctrl_s_axis_tdata = 64'h0100_0000_0000_0001; ctrl_s_axis_tvalid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctrl_s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL desc_drop_ready got %b exp 1", ctrl_s_axis_tready); end
      tick();
      ctrl_s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || desc_valid !== 1'b0) begin
         n_fail++; $display("FAIL desc_drop got err=%b v=%b exp 1 0", err, desc_valid);
      end
   endtask

   task automatic test_errors();
      apply_rst();
      enter_run();
      tick();
      rx_done_valid = 1'b1; rx_done_slot = 4'd2;
      tick();
      rx_done_valid = 1'b0;
      rel_valid = 1'b1; rel_slot = 4'd5; rel_len = 16'd7;
      @(negedge clk);
      n_tests++;
      if (rel_ready !== 1'b1 || err !== 1'b0) begin
         n_fail++; $display("FAIL err_pre got rel_ready=%b err=%b exp 1 0", rel_ready, err);
      end
      tick();
      rel_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (err !== 1'b1 || slot_busy !== 8'h02 || ctrl_m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL err_rel5_%0d got err=%b busy=%h v=%b exp 1 02 0", i, err, slot_busy, ctrl_m_axis_tvalid);
         end
         tick();
      end
      apply_rst();
      enter_run();
      rx_done_valid = 1'b1; rx_done_slot = 4'd0;
      tick();
      rx_done_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || slot_busy !== 8'h00) begin
         n_fail++; $display("FAIL err_rx0 got err=%b busy=%h exp 1 00", err, slot_busy);
      end
      apply_rst();
      rx_done_valid = 1'b1; rx_done_slot = 4'd1;
      tick();
      rx_done_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || slot_busy !== 8'h00) begin
         n_fail++; $display("FAIL err_rx_idle got err=%b busy=%h exp 1 00", err, slot_busy);
      end
      apply_rst();
      enter_run();
      rx_done_valid = 1'b1; rx_done_slot = 4'd6;
      tick();
      rel_valid = 1'b1; rel_slot = 4'd6; rel_len = 16'd9;
      tick();
      rx_done_valid = 1'b0; rel_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || slot_busy !== 8'h00) begin
         n_fail++; $display("FAIL err_same_slot got err=%b busy=%h exp 1 00", err, slot_busy);
      end
      tick();
      ctrl_m_axis_tready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctrl_m_axis_tvalid !== 1'b1 || ctrl_m_axis_tdata !== rel_word(6, 9)) begin
         n_fail++; $display("FAIL err_same_word got v=%b %h exp v=1 %h", ctrl_m_axis_tvalid, ctrl_m_axis_tdata, rel_word(6, 9));
      end
      tick();
      ctrl_m_axis_tready = 1'b0;
   endtask

   // Reference: occupancy array, sticky error flag and an in-order queue of
   // expected release messages.
   task automatic test_random();
      bit                   busy_m [1:SlotCount];
      bit                   err_m;
      logic [63:0]          exp_q [$];
      logic [SlotCount-1:0] exp_busy;
      logic [63:0]          got;
      int                   rs, xs;
      bit                   acc, rel_good, rx_good;
      apply_rst();
      enter_run();
      for (int k = 1; k <= SlotCount; k++) busy_m[k] = 1'b0;
      err_m = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rx_done_valid      = ($urandom_range(0, 9) < 4);
         rx_done_slot       = SlotW'($urandom_range(0, 9));
         rel_valid          = ($urandom_range(0, 9) < 4);
         rel_slot           = SlotW'($urandom_range(0, 9));
         rel_len            = LenW'($urandom);
         ctrl_m_axis_tready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
         for (int k = 1; k <= SlotCount; k++) exp_busy[k-1] = busy_m[k];
         n_tests++;
         if (slot_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %h exp %h", cyc, slot_busy, exp_busy); end
         n_tests++;
         if (err !== err_m) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err, err_m); end
         if (exp_q.size() < SlotCount) begin
            n_tests++;
            if (rel_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_rel_ready cyc %0d got %b exp 1", cyc, rel_ready); end
         end
         if (ctrl_m_axis_tvalid === 1'b1 && ctrl_m_axis_tready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_spurious cyc %0d got %h exp no word", cyc, ctrl_m_axis_tdata);
            end else begin
               got = exp_q.pop_front();
               if (ctrl_m_axis_tdata !== got) begin
                  n_fail++; $display("FAIL rnd_word cyc %0d got %h exp %h", cyc, ctrl_m_axis_tdata, got);
               end
            end
         end
         acc      = rel_valid && (rel_ready === 1'b1);
         rs       = int'(rel_slot);
         xs       = int'(rx_done_slot);
         rel_good = (rs >= 1 && rs <= SlotCount) ? busy_m[rs] : 1'b0;
         rx_good  = (xs >= 1 && xs <= SlotCount) ? !busy_m[xs] : 1'b0;
         if ((acc && !rel_good) || (rx_done_valid && !rx_good)) err_m = 1'b1;
         if (acc && rel_good) begin
            busy_m[rs] = 1'b0;
            exp_q.push_back(rel_word(rs, int'(rel_len)));
         end
         if (rx_done_valid && rx_good) busy_m[xs] = 1'b1;
         tick();
      end
      rx_done_valid = 1'b0; rel_valid = 1'b0; ctrl_m_axis_tready = 1'b1;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (ctrl_m_axis_tvalid === 1'b1) begin
            got = exp_q.pop_front();
            n_tests++;
            if (ctrl_m_axis_tdata !== got) begin
               n_fail++; $display("FAIL rnd_drain got %h exp %h", ctrl_m_axis_tdata, got);
            end
         end
         tick();
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover got %0d words pending exp 0", exp_q.size()); end
      ctrl_m_axis_tready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_init();
      test_release();
      test_back_to_back();
      test_reset_flush();
      test_desc();
      test_errors();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
